// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - direct-mapped BTB with 2-bit direction counters and branch statistics
//
// Purpose:
//   Predicts taken/target in fetch from the fetch PC, checks the decode-stage resolution
//   against the prediction carried down the pipe, drives mispredict/redirect and trains
//   the table. Keeps saturating counts of resolved branches and mispredicts.
//
// Ports:
//   clk, reset_n                     clock, asynchronous active-low reset
//   if_valid, if_pc                  fetch lookup request
//   pred_hit, pred_taken, pred_target  fetch-stage prediction (combinational)
//   res_valid, res_pc, res_uncond,
//   res_taken, res_target            decode-stage branch resolution
//   res_pred_taken, res_pred_tgt     prediction made for the resolving branch
//   mispredict, redirect_pc          flush/redirect request (combinational)
//   stat_branches, stat_mispred      saturating statistics counters

module branch_predict_unit #(
    parameter int         PC_W     = 64,
    parameter int         ENTRIES  = 16,
    parameter int         TAG_W    = 8,
    parameter logic [1:0] CTR_INIT = 2'b01,
    parameter int         STAT_W   = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_valid,
    input  logic [PC_W-1:0]   if_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [PC_W-1:0]   pred_target,
    input  logic              res_valid,
    input  logic [PC_W-1:0]   res_pc,
    input  logic              res_uncond,
    input  logic              res_taken,
    input  logic [PC_W-1:0]   res_target,
    input  logic              res_pred_taken,
    input  logic [PC_W-1:0]   res_pred_tgt,
    output logic              mispredict,
    output logic [PC_W-1:0]   redirect_pc,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispred
);

    localparam int IDX_W = $clog2(ENTRIES);

    // Table state
    logic              valid_q  [ENTRIES];
    logic              valid_d  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [TAG_W-1:0]  tag_d    [ENTRIES];
    logic [PC_W-1:0]   target_q [ENTRIES];
    logic [PC_W-1:0]   target_d [ENTRIES];
    logic [1:0]        ctr_q    [ENTRIES];
    logic [1:0]        ctr_d    [ENTRIES];

    logic [STAT_W-1:0] stat_branches_q, stat_branches_d;
    logic [STAT_W-1:0] stat_mispred_q,  stat_mispred_d;

    // Lookup
    logic [IDX_W-1:0]  if_idx;
    logic [TAG_W-1:0]  if_tag;
    logic              if_hit;

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[IDX_W+2 +: TAG_W];
    assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

    // Outputs are forced low while reset is held, even though the table itself is
    // already cleared, so a lookup during reset cannot report a fall-through target.
    always_comb begin
        pred_hit    = 1'b0;
        pred_taken  = 1'b0;
        pred_target = '0;
        if (reset_n && if_valid) begin
            pred_hit    = if_hit;
            pred_taken  = if_hit && ctr_q[if_idx][1];
            pred_target = if_hit ? target_q[if_idx] : (if_pc + PC_W'(4));
        end
    end

    // Resolution check
    logic [IDX_W-1:0]  res_idx;
    logic [TAG_W-1:0]  res_tag;
    logic              res_hit;
    logic              mispred_raw;

    assign res_idx = res_pc[IDX_W+1:2];
    assign res_tag = res_pc[IDX_W+2 +: TAG_W];
    assign res_hit = valid_q[res_idx] && (tag_q[res_idx] == res_tag);

    assign mispred_raw = res_valid &&
                         ((res_taken != res_pred_taken) ||
                          (res_taken && (res_target != res_pred_tgt)));

    always_comb begin
        mispredict  = 1'b0;
        redirect_pc = '0;
        if (reset_n && res_valid) begin
            mispredict  = mispred_raw;
            redirect_pc = res_taken ? res_target : (res_pc + PC_W'(4));
        end
    end

    // Table training and statistics
    always_comb begin
        valid_d         = valid_q;
        tag_d           = tag_q;
        target_d        = target_q;
        ctr_d           = ctr_q;
        stat_branches_d = stat_branches_q;
        stat_mispred_d  = stat_mispred_q;

        if (res_valid) begin
            if (res_hit) begin
                if (res_uncond) begin
                    ctr_d[res_idx]    = 2'd3;
                    target_d[res_idx] = res_target;
                end else if (res_taken) begin
                    ctr_d[res_idx]    = (ctr_q[res_idx] == 2'd3) ? 2'd3 : ctr_q[res_idx] + 2'd1;
                    target_d[res_idx] = res_target;
                end else begin
                    ctr_d[res_idx]    = (ctr_q[res_idx] == 2'd0) ? 2'd0 : ctr_q[res_idx] - 2'd1;
                end
            end else if (res_taken) begin
                // Allocation overwrites whatever entry currently owns this index.
                valid_d[res_idx]  = 1'b1;
                tag_d[res_idx]    = res_tag;
                target_d[res_idx] = res_target;
                ctr_d[res_idx]    = res_uncond ? 2'd3 : CTR_INIT;
            end

            if (stat_branches_q != {STAT_W{1'b1}}) begin
                stat_branches_d = stat_branches_q + STAT_W'(1);
            end
            if (mispred_raw && (stat_mispred_q != {STAT_W{1'b1}})) begin
                stat_mispred_d = stat_mispred_q + STAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_INIT;
            end
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            valid_q         <= valid_d;
            tag_q           <= tag_d;
            target_q        <= target_d;
            ctr_q           <= ctr_d;
            stat_branches_q <= stat_branches_d;
            stat_mispred_q  <= stat_mispred_d;
        end
    end

    assign stat_branches = stat_branches_q;
    assign stat_mispred  = stat_mispred_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - directed self-checking bench for branch_predict_unit

module tb_branch_predict_unit;

    localparam int PC_W   = 64;
    localparam int STAT_W = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              if_valid;
    logic [PC_W-1:0]   if_pc;
    logic              pred_hit;
    logic              pred_taken;
    logic [PC_W-1:0]   pred_target;
    logic              res_valid;
    logic [PC_W-1:0]   res_pc;
    logic              res_uncond;
    logic              res_taken;
    logic [PC_W-1:0]   res_target;
    logic              res_pred_taken;
    logic [PC_W-1:0]   res_pred_tgt;
    logic              mispredict;
    logic [PC_W-1:0]   redirect_pc;
    logic [STAT_W-1:0] stat_branches;
    logic [STAT_W-1:0] stat_mispred;

    int total = 0;
    int bad   = 0;

    branch_predict_unit #(.PC_W(PC_W), .ENTRIES(16), .TAG_W(8), .CTR_INIT(2'b01), .STAT_W(STAT_W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .pred_hit       (pred_hit),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .res_valid      (res_valid),
        .res_pc         (res_pc),
        .res_uncond     (res_uncond),
        .res_taken      (res_taken),
        .res_target     (res_target),
        .res_pred_taken (res_pred_taken),
        .res_pred_tgt   (res_pred_tgt),
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc),
        .stat_branches  (stat_branches),
        .stat_mispred   (stat_mispred)
    );

    always #5 clk = ~clk;

    task automatic idle();
        if_valid = 1'b0; if_pc = '0;
        res_valid = 1'b0; res_pc = '0; res_uncond = 1'b0; res_taken = 1'b0;
        res_target = '0; res_pred_taken = 1'b0; res_pred_tgt = '0;
    endtask

    task automatic resolve(input logic [PC_W-1:0] pc, input logic unc, input logic tk,
                           input logic [PC_W-1:0] tgt, input logic ptk, input logic [PC_W-1:0] ptgt);
        res_valid = 1'b1; res_pc = pc; res_uncond = unc; res_taken = tk;
        res_target = tgt; res_pred_taken = ptk; res_pred_tgt = ptgt;
    endtask

    task automatic lookup(input logic [PC_W-1:0] pc);
        if_valid = 1'b1; if_pc = pc;
    endtask

    task automatic commit();
        @(posedge clk); #1;
        idle();
    endtask

    task automatic test_reset();
        idle();
        reset_n = 1'b0;
        lookup(64'h40);
        resolve(64'h40, 1'b0, 1'b1, 64'h100, 1'b0, 64'h44);
        @(negedge clk);
        total++; if (pred_hit !== 1'b0) begin bad++; $display("FAIL rst_pred_hit got=%0h want=0", pred_hit); end
        total++; if (pred_target !== 64'h0) begin bad++; $display("FAIL rst_pred_target got=%0h want=0", pred_target); end
        total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL rst_mispredict got=%0h want=0", mispredict); end
        total++; if (redirect_pc !== 64'h0) begin bad++; $display("FAIL rst_redirect got=%0h want=0", redirect_pc); end
        @(posedge clk); #1;
        idle();
        reset_n = 1'b1;
        @(posedge clk); #1;
        lookup(64'h40);
        @(negedge clk);
        total++; if (pred_hit !== 1'b0) begin bad++; $display("FAIL t1_hit got=%0h want=0", pred_hit); end
        total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL t1_taken got=%0h want=0", pred_taken); end
        total++; if (pred_target !== 64'h44) begin bad++; $display("FAIL t1_target got=%0h want=44", pred_target); end
        total++; if (stat_branches !== 4'd0 || stat_mispred !== 4'd0) begin bad++; $display("FAIL t1_stats got=%0d/%0d want=0/0", stat_branches, stat_mispred); end
        total++; if (mispredict !== 1'b0 || redirect_pc !== 64'h0) begin bad++; $display("FAIL t1_nores got=%0h/%0h want=0/0", mispredict, redirect_pc); end
        commit();
    endtask

    task automatic test_allocate();
        resolve(64'h40, 1'b0, 1'b1, 64'h100, 1'b0, 64'h44);
        lookup(64'h40);
        @(negedge clk);
        total++; if (mispredict !== 1'b1) begin bad++; $display("FAIL t2_mispredict got=%0h want=1", mispredict); end
        total++; if (redirect_pc !== 64'h100) begin bad++; $display("FAIL t2_redirect got=%0h want=100", redirect_pc); end
        total++; if (pred_hit !== 1'b0) begin bad++; $display("FAIL t2_sameclk_hit got=%0h want=0", pred_hit); end
        commit();
        lookup(64'h40);
        @(negedge clk);
        total++; if (pred_hit !== 1'b1) begin bad++; $display("FAIL t2_hit got=%0h want=1", pred_hit); end
        total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL t2_taken got=%0h want=0", pred_taken); end
        total++; if (pred_target !== 64'h100) begin bad++; $display("FAIL t2_target got=%0h want=100", pred_target); end
        total++; if (stat_branches !== 4'd1 || stat_mispred !== 4'd1) begin bad++; $display("FAIL t2_stats got=%0d/%0d want=1/1", stat_branches, stat_mispred); end
        commit();
    endtask

    task automatic test_saturate();
        logic       ptk [3] = '{1'b0, 1'b1, 1'b1};
        logic [PC_W-1:0] ptg [3] = '{64'h100, 64'h100, 64'h100};
        logic       exp_mp [3] = '{1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            resolve(64'h40, 1'b0, 1'b1, 64'h100, ptk[i], ptg[i]);
            @(negedge clk);
            total++; if (mispredict !== exp_mp[i]) begin bad++; $display("FAIL t3_mp%0d got=%0h want=%0h", i, mispredict, exp_mp[i]); end
            commit();
        end
        lookup(64'h40);
        @(negedge clk);
        total++; if (pred_taken !== 1'b1 || pred_target !== 64'h100) begin bad++; $display("FAIL t3_sat got=%0h/%0h want=1/100", pred_taken, pred_target); end
        total++; if (stat_branches !== 4'd4 || stat_mispred !== 4'd2) begin bad++; $display("FAIL t3_stats got=%0d/%0d want=4/2", stat_branches, stat_mispred); end
        commit();
        resolve(64'h40, 1'b0, 1'b0, 64'h100, 1'b1, 64'h100);
        @(negedge clk);
        total++; if (mispredict !== 1'b1 || redirect_pc !== 64'h44) begin bad++; $display("FAIL t3_nt got=%0h/%0h want=1/44", mispredict, redirect_pc); end
        commit();
        lookup(64'h40);
        @(negedge clk);
        total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL t3_ctr2 got=%0h want=1", pred_taken); end
        commit();
        resolve(64'h40, 1'b0, 1'b0, 64'h100, 1'b1, 64'h100);
        commit();
        lookup(64'h40);
        @(negedge clk);
        total++; if (pred_hit !== 1'b1 || pred_taken !== 1'b0) begin bad++; $display("FAIL t3_ctr1 got=%0h/%0h want=1/0", pred_hit, pred_taken); end
        total++; if (stat_branches !== 4'd6 || stat_mispred !== 4'd4) begin bad++; $display("FAIL t3_stats2 got=%0d/%0d want=6/4", stat_branches, stat_mispred); end
        commit();
    endtask

    task automatic test_alias();
        resolve(64'h80, 1'b0, 1'b1, 64'h300, 1'b0, 64'h84);
        lookup(64'h40);
        @(negedge clk);
        total++; if (pred_hit !== 1'b1 || pred_target !== 64'h100) begin bad++; $display("FAIL t4_old got=%0h/%0h want=1/100", pred_hit, pred_target); end
        total++; if (mispredict !== 1'b1 || redirect_pc !== 64'h300) begin bad++; $display("FAIL t4_mp got=%0h/%0h want=1/300", mispredict, redirect_pc); end
        commit();
        lookup(64'h40);
        @(negedge clk);
        total++; if (pred_hit !== 1'b0 || pred_target !== 64'h44) begin bad++; $display("FAIL t4_evict got=%0h/%0h want=0/44", pred_hit, pred_target); end
        commit();
        lookup(64'h80);
        @(negedge clk);
        total++; if (pred_hit !== 1'b1 || pred_taken !== 1'b0 || pred_target !== 64'h300) begin bad++; $display("FAIL t4_new got=%0h/%0h/%0h want=1/0/300", pred_hit, pred_taken, pred_target); end
        commit();
    endtask

    task automatic test_uncond();
        resolve(64'h200, 1'b1, 1'b1, 64'h0, 1'b0, 64'h204);
        @(negedge clk);
        total++; if (mispredict !== 1'b1 || redirect_pc !== 64'h0) begin bad++; $display("FAIL t5_mp got=%0h/%0h want=1/0", mispredict, redirect_pc); end
        commit();
        lookup(64'h200);
        @(negedge clk);
        total++; if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 64'h0) begin bad++; $display("FAIL t5_pred got=%0h/%0h/%0h want=1/1/0", pred_hit, pred_taken, pred_target); end
        commit();
        resolve(64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 64'h1234, 1'b0, 64'h0);
        @(negedge clk);
        total++; if (mispredict !== 1'b0 || redirect_pc !== 64'h0) begin bad++; $display("FAIL t5_wrap got=%0h/%0h want=0/0", mispredict, redirect_pc); end
        commit();
        lookup(64'hFFFF_FFFF_FFFF_FFFC);
        @(negedge clk);
        total++; if (pred_hit !== 1'b0 || pred_target !== 64'h0) begin bad++; $display("FAIL t5_nt_noalloc got=%0h/%0h want=0/0", pred_hit, pred_target); end
        commit();
        resolve(64'h200, 1'b1, 1'b1, 64'h500, 1'b1, 64'h0);
        @(negedge clk);
        total++; if (mispredict !== 1'b1 || redirect_pc !== 64'h500) begin bad++; $display("FAIL t5_tgt_mp got=%0h/%0h want=1/500", mispredict, redirect_pc); end
        commit();
        lookup(64'h200);
        @(negedge clk);
        total++; if (pred_taken !== 1'b1 || pred_target !== 64'h500) begin bad++; $display("FAIL t5_retarget got=%0h/%0h want=1/500", pred_taken, pred_target); end
        total++; if (stat_branches !== 4'd10 || stat_mispred !== 4'd7) begin bad++; $display("FAIL t5_stats got=%0d/%0d want=10/7", stat_branches, stat_mispred); end
        commit();
    endtask

    task automatic test_stat_saturate_and_reset();
        for (int i = 0; i < 10; i++) begin
            resolve(64'h1000, 1'b0, 1'b1, 64'h2000, 1'b0, 64'h0);
            commit();
            if (i == 4) begin
                total++; if (stat_branches !== 4'd15 || stat_mispred !== 4'd12) begin bad++; $display("FAIL t6_mid got=%0d/%0d want=15/12", stat_branches, stat_mispred); end
            end
        end
        total++; if (stat_branches !== 4'd15 || stat_mispred !== 4'd15) begin bad++; $display("FAIL t6_sat got=%0d/%0d want=15/15", stat_branches, stat_mispred); end
        resolve(64'h40, 1'b0, 1'b1, 64'h700, 1'b0, 64'h44);
        #2;
        reset_n = 1'b0;
        #1;
        total++; if (stat_branches !== 4'd0 || stat_mispred !== 4'd0) begin bad++; $display("FAIL t6_rst_stats got=%0d/%0d want=0/0", stat_branches, stat_mispred); end
        total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL t6_rst_mp got=%0h want=0", mispredict); end
        @(posedge clk); #1;
        idle();
        reset_n = 1'b1;
        @(posedge clk); #1;
        lookup(64'h40);
        @(negedge clk);
        total++; if (pred_hit !== 1'b0 || pred_target !== 64'h44) begin bad++; $display("FAIL t6_no_partial got=%0h/%0h want=0/44", pred_hit, pred_target); end
        commit();
        lookup(64'h200);
        @(negedge clk);
        total++; if (pred_hit !== 1'b0 || pred_target !== 64'h204) begin bad++; $display("FAIL t6_cleared got=%0h/%0h want=0/204", pred_hit, pred_target); end
        total++; if (stat_branches !== 4'd0 || stat_mispred !== 4'd0) begin bad++; $display("FAIL t6_post_stats got=%0d/%0d want=0/0", stat_branches, stat_mispred); end
        commit();
    endtask

    initial begin
        test_reset();
        test_allocate();
        test_saturate();
        test_alias();
        test_uncond();
        test_stat_saturate_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
